// File: rtl/fg_prog_sequencer.sv
// Programming-mux sequencer for a floating-gate tile frame: run/program mode changes with break-before-make, then timed gate/drain pulses.
// Optional FG_PROG_ABORT_EN adds an abort input that ends a pulse early.
module fg_prog_sequencer #(
  parameter int DRAIN_BITS = 5,
  parameter int GATE_BITS  = 2,
  parameter int PULSE_W    = 16,
  parameter int SETTLE_CYC = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_exit,
  input  logic [DRAIN_BITS-1:0] cmd_drain,
  input  logic [GATE_BITS-1:0]  cmd_gate,
  input  logic [PULSE_W-1:0]    cmd_pulse,
`ifdef FG_PROG_ABORT_EN
  input  logic                  abort,
`endif
  output logic                  prog,
  output logic                  run,
  output logic                  vgprog,
  output logic                  vgrun,
  output logic                  gate_enable,
  output logic [GATE_BITS-1:0]  gate_b,
  output logic                  drain_enable,
  output logic [DRAIN_BITS-1:0] drain_b,
  output logic                  busy,
  output logic                  done
);

  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {
    S_RUN, S_BBM_IN, S_SETUP, S_PULSE, S_HOLD, S_PIDLE, S_BBM_OUT
  } state_t;

  state_t                state;
  logic [SW-1:0]         settle_cnt;
  logic [PULSE_W-1:0]    pulse_cnt;
  logic [PULSE_W-1:0]    pulse_len;
  logic [DRAIN_BITS-1:0] lat_drain;
  logic [GATE_BITS-1:0]  lat_gate;
  logic [PULSE_W-1:0]    pulse_eff;
  logic                  accept;
  logic                  abort_hit;

  assign accept    = cmd_valid & cmd_ready;
  assign pulse_eff = (cmd_pulse == '0) ? PULSE_W'(1) : cmd_pulse;
`ifdef FG_PROG_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_RUN;
      settle_cnt   <= '0;
      pulse_cnt    <= '0;
      pulse_len    <= '0;
      lat_drain    <= '0;
      lat_gate     <= '0;
      cmd_ready    <= 1'b1;
      prog         <= 1'b0;
      run          <= 1'b1;
      vgprog       <= 1'b0;
      vgrun        <= 1'b1;
      gate_enable  <= 1'b0;
      drain_enable <= 1'b0;
      gate_b       <= '1;
      drain_b      <= '1;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_RUN: begin
          if (accept) begin
            if (cmd_exit) begin
              done <= 1'b1;
            end else begin
              lat_drain <= cmd_drain;
              lat_gate  <= cmd_gate;
              pulse_len <= pulse_eff;
              run       <= 1'b0;
              vgrun     <= 1'b0;
              cmd_ready <= 1'b0;
              busy      <= 1'b1;
              state     <= S_BBM_IN;
            end
          end
        end
        S_BBM_IN: begin
          prog       <= 1'b1;
          vgprog     <= 1'b1;
          gate_b     <= ~lat_gate;
          drain_b    <= ~lat_drain;
          settle_cnt <= SETTLE_LOAD;
          state      <= S_SETUP;
        end
        S_SETUP: begin
          if (settle_cnt == '0) begin
            gate_enable  <= 1'b1;
            drain_enable <= 1'b1;
            pulse_cnt    <= pulse_len;
            state        <= S_PULSE;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        S_PULSE: begin
          // Counter terminates at 1 so a full-scale length never wraps
          if (pulse_cnt == PULSE_W'(1) || abort_hit) begin
            gate_enable  <= 1'b0;
            drain_enable <= 1'b0;
            settle_cnt   <= SETTLE_LOAD;
            state        <= S_HOLD;
          end else begin
            pulse_cnt <= pulse_cnt - 1'b1;
          end
        end
        S_HOLD: begin
          if (settle_cnt == '0) begin
            gate_b    <= '1;
            drain_b   <= '1;
            done      <= 1'b1;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= S_PIDLE;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        S_PIDLE: begin
          if (accept) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            if (cmd_exit) begin
              prog   <= 1'b0;
              vgprog <= 1'b0;
              state  <= S_BBM_OUT;
            end else begin
              pulse_len  <= pulse_eff;
              gate_b     <= ~cmd_gate;
              drain_b    <= ~cmd_drain;
              settle_cnt <= SETTLE_LOAD;
              state      <= S_SETUP;
            end
          end
        end
        S_BBM_OUT: begin
          run       <= 1'b1;
          vgrun     <= 1'b1;
          done      <= 1'b1;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= S_RUN;
        end
        default: state <= S_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_fg_prog_sequencer.sv
// Self-checking bench for fg_prog_sequencer: scoreboard of expected completions plus per-cycle invariant monitor.
// Build with FG_PROG_ABORT_EN defined to also exercise the abort path.
module tb_fg_prog_sequencer;
  localparam int S = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_exit = 1'b0;
  logic [4:0]  cmd_drain = '0;
  logic [1:0]  cmd_gate = '0;
  logic [15:0] cmd_pulse = '0;
`ifdef FG_PROG_ABORT_EN
  logic        abort = 1'b0;
`endif
  logic prog, run, vgprog, vgrun, gate_enable, drain_enable, busy, done;
  logic [1:0] gate_b;
  logic [4:0] drain_b;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit m_prog = 0;

  typedef struct {
    int         done_cyc;
    int         pstart;
    int         en_cnt;
    bit         inject;
    logic [4:0] drain_b;
    logic [1:0] gate_b;
  } exp_t;
  exp_t q[$];

  fg_prog_sequencer #(.DRAIN_BITS(5), .GATE_BITS(2), .PULSE_W(16), .SETTLE_CYC(S)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_exit(cmd_exit), .cmd_drain(cmd_drain), .cmd_gate(cmd_gate), .cmd_pulse(cmd_pulse),
`ifdef FG_PROG_ABORT_EN
    .abort(abort),
`endif
    .prog(prog), .run(run), .vgprog(vgprog), .vgrun(vgrun),
    .gate_enable(gate_enable), .gate_b(gate_b), .drain_enable(drain_enable), .drain_b(drain_b),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: invariants every cycle, scoreboard pop on done
  int         en_cnt = 0;
  int         en_first = -1;
  logic [4:0] cap_drain;
  logic [1:0] cap_gate;
  logic       prev_en = 1'b0;
  logic [4:0] prev_drain;
  logic [1:0] prev_gate;
  always @(negedge clk) begin
    if (!rst_n) begin
      en_cnt = 0; en_first = -1; prev_en = 1'b0;
    end else begin
      checks++;
      if (((prog & run) | (vgprog & vgrun)) !== 1'b0) begin
        errors++; $display("FAIL mode_overlap cyc=%0d prog=%b run=%b vgprog=%b vgrun=%b", cyc, prog, run, vgprog, vgrun);
      end
      checks++;
      if (gate_enable !== drain_enable || cmd_ready !== ~busy) begin
        errors++; $display("FAIL enable_ready_consistency cyc=%0d ge=%b de=%b ready=%b busy=%b", cyc, gate_enable, drain_enable, cmd_ready, busy);
      end
      if (gate_enable && prev_en) begin
        checks++;
        if (drain_b !== prev_drain || gate_b !== prev_gate) begin
          errors++; $display("FAIL addr_stable cyc=%0d drain_b=%b was %b gate_b=%b was %b", cyc, drain_b, prev_drain, gate_b, prev_gate);
        end
      end
      if (gate_enable) begin
        if (en_cnt == 0) begin en_first = cyc; cap_drain = drain_b; cap_gate = gate_b; end
        en_cnt++;
      end
      prev_en = gate_enable; prev_drain = drain_b; prev_gate = gate_b;
      if (done === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL unexpected_done cyc=%0d got done=1 want none", cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (cyc !== e.done_cyc || en_cnt !== e.en_cnt) begin
            errors++; $display("FAIL done_timing cyc=%0d want %0d, pulse_len=%0d want %0d", cyc, e.done_cyc, en_cnt, e.en_cnt);
          end
          if (e.inject) begin
            checks++;
            if (en_first !== e.pstart || cap_drain !== e.drain_b || cap_gate !== e.gate_b) begin
              errors++; $display("FAIL pulse_window start=%0d want %0d drain_b=%b want %b gate_b=%b want %b",
                                 en_first, e.pstart, cap_drain, e.drain_b, cap_gate, e.gate_b);
            end
          end
        end
        en_cnt = 0; en_first = -1;
      end
    end
  end

  // Drive one command, wait for acceptance, push its expected completion.
  // en_ovr > 0 overrides the expected pulse length (used for abort).
  task automatic send(input logic ex, input logic [4:0] d, input logic [1:0] g,
                      input logic [15:0] p, input int en_ovr, output int acc);
    int n, np, bbm;
    exp_t e;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_exit = ex; cmd_drain = d; cmd_gate = g; cmd_pulse = p;
    n = 0;
    while (!cmd_ready && n < 5000) begin @(negedge clk); n++; end
    if (!cmd_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout cmd_ready=%b want 1", cmd_ready);
      cmd_valid = 1'b0; acc = -1;
      return;
    end
    acc = cyc;
    np = (en_ovr > 0) ? en_ovr : ((p == 16'd0) ? 1 : int'(p));
    bbm = m_prog ? 0 : 1;
    e.inject = !ex; e.drain_b = ~d; e.gate_b = ~g; e.en_cnt = 0; e.pstart = -1;
    if (ex) e.done_cyc = acc + (m_prog ? 2 : 1);
    else begin
      e.pstart = acc + 1 + bbm + S;
      e.en_cnt = np;
      e.done_cyc = e.pstart + np + S;
    end
    q.push_back(e);
    if (ex) m_prog = 0; else m_prog = 1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin @(negedge clk); n++; end
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL done_timeout pending=%0d want 0", q.size());
      q.delete();
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({run, vgrun, prog, vgprog, gate_enable, drain_enable, gate_b, drain_b, cmd_ready, busy, done}
        !== {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 5'b11111, 1'b1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL reset_values run=%b vgrun=%b prog=%b vgprog=%b en=%b%b gate_b=%b drain_b=%b ready=%b busy=%b done=%b",
                         run, vgrun, prog, vgprog, gate_enable, drain_enable, gate_b, drain_b, cmd_ready, busy, done);
    end
  endtask

  task automatic test_inject_from_run();
    int a;
    send(1'b0, 5'd9, 2'd2, 16'd100, 0, a);
    checks++;
    if ({run, vgrun, prog, vgprog} !== 4'b0000 || busy !== 1'b1 || cmd_ready !== 1'b0) begin
      errors++; $display("FAIL bbm_in run=%b vgrun=%b prog=%b vgprog=%b busy=%b ready=%b want 0000 1 0", run, vgrun, prog, vgprog, busy, cmd_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (drain_b !== 5'b10110 || gate_b !== 2'b01 || gate_enable !== 1'b0 || {prog, vgprog} !== 2'b11) begin
      errors++; $display("FAIL setup_addr drain_b=%b want 10110 gate_b=%b want 01 en=%b prog=%b vgprog=%b", drain_b, gate_b, gate_enable, prog, vgprog);
    end
    wait_idle(500);
    checks++;
    if ({prog, vgprog, run, vgrun} !== 4'b1100 || drain_b !== 5'b11111 || gate_b !== 2'b11 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL pidle_state prog=%b vgprog=%b run=%b vgrun=%b drain_b=%b gate_b=%b ready=%b", prog, vgprog, run, vgrun, drain_b, gate_b, cmd_ready);
    end
  endtask

  task automatic test_inject_pidle_zero();
    int a;
    send(1'b0, 5'd31, 2'd0, 16'd0, 0, a);
    checks++;
    if ({prog, vgprog, run, vgrun} !== 4'b1100 || drain_b !== 5'b00000 || gate_b !== 2'b11) begin
      errors++; $display("FAIL no_bbm prog=%b vgprog=%b run=%b vgrun=%b drain_b=%b gate_b=%b", prog, vgprog, run, vgrun, drain_b, gate_b);
    end
    wait_idle(500);
  endtask

  task automatic test_exit_pidle();
    int a;
    send(1'b1, 5'd0, 2'd0, 16'd0, 0, a);
    checks++;
    if ({run, vgrun, prog, vgprog} !== 4'b0000 || busy !== 1'b1 || cmd_ready !== 1'b0) begin
      errors++; $display("FAIL bbm_out run=%b vgrun=%b prog=%b vgprog=%b busy=%b ready=%b", run, vgrun, prog, vgprog, busy, cmd_ready);
    end
    @(posedge clk); #1;
    checks++;
    if ({run, vgrun, prog, vgprog, done} !== 5'b11001) begin
      errors++; $display("FAIL exit_run run=%b vgrun=%b prog=%b vgprog=%b done=%b want 11001", run, vgrun, prog, vgprog, done);
    end
    wait_idle(50);
  endtask

  task automatic test_exit_from_run();
    int a;
    send(1'b1, 5'd3, 2'd1, 16'd5, 0, a);
    wait_idle(50);
    checks++;
    if ({run, vgrun, prog, vgprog, busy} !== 5'b11000) begin
      errors++; $display("FAIL exit_in_run run=%b vgrun=%b prog=%b vgprog=%b busy=%b", run, vgrun, prog, vgprog, busy);
    end
  endtask

  task automatic test_back_to_back();
    int a;
    send(1'b0, 5'd17, 2'd3, 16'd3, 0, a);
    send(1'b0, 5'd4, 2'd1, 16'd2, 0, a);
    send(1'b1, 5'd0, 2'd0, 16'd0, 0, a);
    wait_idle(500);
  endtask

  task automatic test_random();
    int a;
    for (int i = 0; i < 6; i++) begin
      send(($urandom_range(0, 3) == 0), 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
           16'($urandom_range(0, 40)), 0, a);
    end
    wait_idle(1000);
    if (m_prog) begin send(1'b1, 5'd0, 2'd0, 16'd0, 0, a); wait_idle(50); end
  endtask

  task automatic test_reset_mid_pulse();
    int a, n;
    send(1'b0, 5'd21, 2'd1, 16'd1000, 0, a);
    n = 0;
    while (gate_enable !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (gate_enable !== 1'b0 || drain_enable !== 1'b0) begin
      errors++; $display("FAIL async_reset_enables ge=%b de=%b want 0 0", gate_enable, drain_enable);
    end
    q.delete(); m_prog = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({run, vgrun, prog, vgprog, gate_b, drain_b, cmd_ready, busy, done} !== {4'b1100, 2'b11, 5'b11111, 3'b100}) begin
      errors++; $display("FAIL reset_mid_pulse run=%b vgrun=%b prog=%b vgprog=%b gate_b=%b drain_b=%b ready=%b busy=%b done=%b",
                         run, vgrun, prog, vgprog, gate_b, drain_b, cmd_ready, busy, done);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

`ifdef FG_PROG_ABORT_EN
  task automatic test_abort();
    int a;
    send(1'b0, 5'd6, 2'd2, 16'd1000, 0, a);
    wait_idle(500);
    send(1'b0, 5'd12, 2'd1, 16'd1000, 6, a);
    // from PIDLE the pulse starts at a+1+S; raise abort in pulse cycle 5
    while (cyc < a + 1 + S + 5) @(negedge clk);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    wait_idle(500);
    send(1'b1, 5'd0, 2'd0, 16'd0, 0, a);
    wait_idle(50);
  endtask
`endif

  initial begin
    test_reset();
    test_inject_from_run();
    test_inject_pidle_zero();
    test_exit_pidle();
    test_exit_from_run();
    test_back_to_back();
    test_random();
`ifdef FG_PROG_ABORT_EN
    test_abort();
`endif
    test_reset_mid_pulse();
    test_inject_from_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout cyc=%0d want finish", cyc);
    $fatal(1, "timeout");
  end
endmodule
